cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter ROM_SIZE, default 256, number of valid instruction words; any ip >= ROM_SIZE is out of range.
REQ-002 Parameter STALL_LIMIT, default 255, maximum cycles spent waiting for misc_ack.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 run  input  1  level; 1 permits starting a new instruction.
REQ-006 ip  input  16  current instruction pointer from the IP register.
REQ-007 dec_reg_we, dec_misc_cs  input  1 each  decoder intent: register write, misc/IO operation.
REQ-008 misc_ack  input  1  misc manager has completed the requested operation.
REQ-009 step_en, step_req  input  1 each  single-step mode select and one-cycle advance pulse.
REQ-010 ir_load  output  1  one-cycle pulse latching rom[ip] into the instruction register.
REQ-011 misc_req  output  1  level request to the misc manager.
REQ-012 reg_we  output  1  gated register-file write enable.
REQ-013 ip_step  output  1  one-cycle pulse enabling the IP increment or jump.
REQ-014 halted, err_range, err_timeout  output  1 each  halt flag and its sticky cause.
REQ-015 step_ack  output  1  one-cycle pulse when a stepped instruction retires.
REQ-016 retired  output  32  count of retired instructions.

Function
REQ-017 States SHALL be IDLE, FETCH, EXEC, WAIT_IO, WB, STEP_WAIT, HALT.
REQ-018 IDLE->FETCH when run=1; otherwise remain in IDLE.
REQ-019 FETCH: if ip >= ROM_SIZE, go to HALT with err_range=1 and no ir_load; else pulse ir_load and go to EXEC.
REQ-020 EXEC: misc_req=dec_misc_cs; non-misc goes to WB; misc with misc_ack=1 in the same cycle goes to WB; misc with misc_ack=0 goes to WAIT_IO.
REQ-021 WAIT_IO: hold misc_req=1; misc_ack=1 goes to WB; after STALL_LIMIT cycles without ack, go to HALT with err_timeout=1.
REQ-022 WB: reg_we=dec_reg_we and ip_step=1 for exactly one cycle; retired increments by 1, wrapping 2^32-1 -> 0.
REQ-023 After WB: go to STEP_WAIT when step-mode is active; else go to FETCH if run=1, else IDLE.
REQ-024 run deasserted mid-instruction SHALL NOT abort the instruction; the instruction completes through WB.
REQ-025 A non-misc instruction SHALL take exactly 3 cycles from FETCH entry to WB exit.
REQ-026 misc_req SHALL be 0 in all states except EXEC (misc instructions) and WAIT_IO.
REQ-027 HALT is absorbing until rst: halted=1, all strobes 0, and the error flags hold their values.
REQ-028 misc_ack outside EXEC and WAIT_IO SHALL be ignored.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE from any state, including WAIT_IO and HALT.
REQ-030 Reset values: all strobes 0, misc_req=0, halted=0, both error flags 0, retired=0, stall counter 0.
REQ-031 The cycle after reset SHALL NOT produce ir_load, reg_we or ip_step.

Configuration
REQ-032 Macro CPU_SEQ_SINGLE_STEP_EN SHALL compile single-stepping in or out.
REQ-033 With CPU_SEQ_SINGLE_STEP_EN defined: step-mode is active when step_en=1; STEP_WAIT pulses step_ack on entry and waits for step_req=1, then goes to FETCH, or to IDLE if run=0.
REQ-034 With CPU_SEQ_SINGLE_STEP_EN undefined: step_en and step_req ports exist and are ignored, step_ack is tied to 0, and STEP_WAIT is unreachable.

Structure
REQ-035 Package cpu_pkg SHALL hold the enum seq_state_t, the halt-cause typedef, and the width constant for retired.
REQ-036 Sub-module cpu_seq_stall_timer SHALL implement the WAIT_IO counter: clear, enable, expire at STALL_LIMIT.

Verification
REQ-037 rst, run=1, three ALU ops at ip 0..2 -> ir_load pulses 3 cycles apart; retired=3; three ip_step pulses.
REQ-038 Misc op with misc_ack 4 cycles after misc_req rises -> WB one cycle after ack; reg_we=dec_reg_we; misc_req then drops to 0.
REQ-039 Misc op with misc_ack never asserted, STALL_LIMIT=8 -> halted=1 and err_timeout=1 after 8 WAIT_IO cycles; rst returns to IDLE with flags 0.
REQ-040 ip=256 with ROM_SIZE=256 -> HALT; err_range=1; no ir_load pulse.
REQ-041 rst asserted during WAIT_IO -> misc_req=0 and state IDLE after that edge; no reg_we.
REQ-042 CPU_SEQ_SINGLE_STEP_EN defined, step_en=1 -> one instruction retires, step_ack pulses, stall until step_req; retired preset to 32'hFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the CPU sequencer: FSM state encoding, halt cause, retired-counter width.
package cpu_pkg;

  localparam int unsigned RETIRED_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    WAIT_IO,
    WB,
    STEP_WAIT,
    HALT
  } seq_state_t;

  typedef struct packed {
    logic range;
    logic timeout;
  } halt_cause_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Request/acknowledge handshake between the sequencer and the misc/IO manager.
interface cpu_sequencer_if;
  logic misc_req;
  logic misc_ack;

  modport master (output misc_req, input misc_ack);
  modport slave  (input misc_req, output misc_ack);
endinterface

// File: rtl/cpu_sequencer_stall_timer.sv
// WAIT_IO stall counter: counts enabled cycles and flags the STALL_LIMIT-th one.
module cpu_seq_stall_timer #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  // Fires during the last permitted waiting cycle, so the FSM leaves on its edge.
  assign expired = en && (count == CW'(STALL_LIMIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch / execute / misc wait / writeback with halt on range or stall errors.
// Optional single-step support compiled in with `define CPU_SEQ_SINGLE_STEP_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ROM_SIZE    = 256,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [15:0]          ip,
  input  logic                 dec_reg_we,
  input  logic                 dec_misc_cs,
  cpu_sequencer_if.master      misc,
  input  logic                 step_en,
  input  logic                 step_req,
  output logic                 ir_load,
  output logic                 reg_we,
  output logic                 ip_step,
  output logic                 halted,
  output logic                 err_range,
  output logic                 err_timeout,
  output logic                 step_ack,
  output logic [RETIRED_W-1:0] retired
);

  seq_state_t             state, next;
  halt_cause_t            cause_q, cause_d;
  logic [RETIRED_W-1:0]   retired_q;
  logic                   in_range;
  logic                   stall_expired;
  logic                   step_mode;

  assign in_range = 32'(ip) < ROM_SIZE;

  cpu_seq_stall_timer #(.STALL_LIMIT(STALL_LIMIT)) u_stall (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != WAIT_IO),
    .en      (state == WAIT_IO),
    .expired (stall_expired)
  );

`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic step_ack_q;

  assign step_mode = step_en;
  assign step_ack  = step_ack_q;

  always_ff @(posedge clk) begin
    if (rst) step_ack_q <= 1'b0;
    else     step_ack_q <= (state == WB) && (next == STEP_WAIT);
  end
`else
  logic unused_step;

  assign unused_step = step_en ^ step_req;
  assign step_mode   = 1'b0;
  assign step_ack    = 1'b0;
`endif

  always_comb begin
    next          = state;
    cause_d       = cause_q;
    ir_load       = 1'b0;
    misc.misc_req = 1'b0;
    reg_we        = 1'b0;
    ip_step       = 1'b0;
    case (state)
      IDLE: if (run) next = FETCH;
      FETCH: begin
        if (!in_range) begin
          next          = HALT;
          cause_d.range = 1'b1;
        end else begin
          ir_load = 1'b1;
          next    = EXEC;
        end
      end
      EXEC: begin
        misc.misc_req = dec_misc_cs;
        if (!dec_misc_cs || misc.misc_ack) next = WB;
        else                               next = WAIT_IO;
      end
      WAIT_IO: begin
        misc.misc_req = 1'b1;
        if (misc.misc_ack) begin
          next = WB;
        end else if (stall_expired) begin
          next            = HALT;
          cause_d.timeout = 1'b1;
        end
      end
      WB: begin
        reg_we  = dec_reg_we;
        ip_step = 1'b1;
        if (step_mode) next = STEP_WAIT;
        else if (run)  next = FETCH;
        else           next = IDLE;
      end
      STEP_WAIT: begin
`ifdef CPU_SEQ_SINGLE_STEP_EN
        if (step_req) next = run ? FETCH : IDLE;
`else
        next = IDLE;
`endif
      end
      HALT: next = HALT;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cause_q   <= '0;
      retired_q <= '0;
    end else begin
      state   <= next;
      cause_q <= cause_d;
      if (state == WB) retired_q <= retired_q + RETIRED_W'(1);
    end
  end

  assign halted      = (state == HALT);
  assign err_range   = cause_q.range;
  assign err_timeout = cause_q.timeout;
  assign retired     = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed table, hand sequences and randomized instructions.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int unsigned ROM = 256;
  localparam int unsigned SL  = 8;

  logic        clk = 1'b0;
  logic        rst, run, dec_reg_we, dec_misc_cs, step_en, step_req;
  logic [15:0] ip;
  logic        ir_load, reg_we, ip_step, halted, err_range, err_timeout, step_ack;
  logic [31:0] retired;

  cpu_sequencer_if bus();

  cpu_sequencer #(.ROM_SIZE(ROM), .STALL_LIMIT(SL)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .ip          (ip),
    .dec_reg_we  (dec_reg_we),
    .dec_misc_cs (dec_misc_cs),
    .misc        (bus),
    .step_en     (step_en),
    .step_req    (step_req),
    .ir_load     (ir_load),
    .reg_we      (reg_we),
    .ip_step     (ip_step),
    .halted      (halted),
    .err_range   (err_range),
    .err_timeout (err_timeout),
    .step_ack    (step_ack),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_retired;
  bit          step_noise;

  typedef struct {
    logic [15:0] ip;
    bit          misc;
    bit          we;
    int unsigned dly;
    int          exp_end;
    bit          exp_rng;
    bit          exp_to;
  } vec_t;

  // {ir_load, misc_req, reg_we, ip_step, halted, step_ack}
  function automatic logic [5:0] obs();
    return {ir_load, bus.misc_req, reg_we, ip_step, halted, step_ack};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction timeline from the rules: FETCH at 0, EXEC at 1, ack delay stretches WAIT_IO.
  function automatic int model_end(input logic [15:0] i_ip, input bit misc, input int unsigned dly,
                                   output bit rng, output bit to);
    rng = (32'(i_ip) >= ROM);
    to  = !rng && misc && (dly > SL);
    if (rng) return 1;
    if (to)  return 2 + SL;
    return 2 + (misc ? int'(dly) : 0);
  endfunction

  task automatic noise_step();
    step_en  = step_noise ? 1'($urandom) : 1'b0;
    step_req = step_noise ? 1'($urandom) : 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; bus.misc_ack = 1'b0; step_en = 1'b0; step_req = 1'b0;
    dec_reg_we = 1'b0; dec_misc_cs = 1'b0; ip = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outs", 32'(obs()), 32'd0);
    check("reset_err", {30'd0, err_range, err_timeout}, 32'd0);
    check("reset_retired", retired, 32'd0);
    exp_retired = '0;
  endtask

  // Starts in IDLE; ends in IDLE (after retiring) or after reset (after a halt).
  task automatic run_instr(input string name, input logic [15:0] i_ip, input bit misc, input bit we,
                           input int unsigned dly, input int exp_end, input bit exp_rng, input bit exp_to);
    bit         ended_halt;
    logic [5:0] exp_o;
    ended_halt = exp_rng || exp_to;
    @(negedge clk);
    ip = i_ip; dec_misc_cs = misc; dec_reg_we = we; run = 1'b1;
    bus.misc_ack = 1'($urandom); noise_step();
    #1 check({name, "_idle"}, 32'(obs()), 32'd0);
    for (int k = 0; k <= exp_end; k++) begin
      @(negedge clk);
      run = (k == exp_end) ? 1'b0 : 1'($urandom);
      if (misc && k >= 1 && k <= 1 + int'(dly)) bus.misc_ack = (k == 1 + int'(dly));
      else                                      bus.misc_ack = 1'($urandom);
      noise_step();
      exp_o = {k == 0 && !exp_rng,
               misc && !exp_rng && k >= 1 && k < exp_end,
               !ended_halt && k == exp_end && we,
               !ended_halt && k == exp_end,
               ended_halt && k == exp_end,
               1'b0};
      #1 check($sformatf("%s_c%0d", name, k), 32'(obs()), 32'(exp_o));
    end
    @(negedge clk);
    run = 1'b0; bus.misc_ack = 1'($urandom); noise_step();
    #1;
    if (ended_halt) begin
      check({name, "_halt_hold"}, 32'(obs()), 32'b000010);
      check({name, "_err"}, {30'd0, err_range, err_timeout}, {30'd0, exp_rng, exp_to});
      check({name, "_retired"}, retired, exp_retired);
      do_reset();
    end else begin
      exp_retired = exp_retired + 32'd1;
      check({name, "_after"}, 32'(obs()), 32'd0);
      check({name, "_retired"}, retired, exp_retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [9];
    vec_t        v;
    int          n_ir, n_step, e;
    bit          r, t;
    logic [5:0]  exp_s [9];

    step_noise = 1'b0;
    do_reset();

    tbl[0] = '{16'd0,      1'b0, 1'b1, 0, 2,  1'b0, 1'b0};
    tbl[1] = '{16'd5,      1'b1, 1'b1, 0, 2,  1'b0, 1'b0};
    tbl[2] = '{16'd7,      1'b1, 1'b0, 4, 6,  1'b0, 1'b0};
    tbl[3] = '{16'd255,    1'b0, 1'b0, 0, 2,  1'b0, 1'b0};
    tbl[4] = '{16'd256,    1'b0, 1'b1, 0, 1,  1'b1, 1'b0};
    tbl[5] = '{16'hFFFF,   1'b1, 1'b1, 3, 1,  1'b1, 1'b0};
    tbl[6] = '{16'd3,      1'b1, 1'b1, 8, 10, 1'b0, 1'b0};
    tbl[7] = '{16'd3,      1'b1, 1'b1, 9, 10, 1'b0, 1'b1};
    tbl[8] = '{16'd1,      1'b1, 1'b0, 1, 3,  1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      run_instr($sformatf("tbl%0d", i), tbl[i].ip, tbl[i].misc, tbl[i].we, tbl[i].dly,
                tbl[i].exp_end, tbl[i].exp_rng, tbl[i].exp_to);

    // Three back-to-back ALU ops at ip 0..2 with run held high.
    n_ir = 0; n_step = 0;
    @(negedge clk);
    run = 1'b1; dec_misc_cs = 1'b0; dec_reg_we = 1'b1; ip = 16'd0; bus.misc_ack = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      ip = 16'(k / 3);
      run = (k == 8) ? 1'b0 : 1'b1;
      #1;
      n_ir   += int'(ir_load);
      n_step += int'(ip_step);
      check($sformatf("b2b_ir_c%0d", k), 32'(ir_load), 32'((k % 3) == 0));
    end
    @(negedge clk);
    #1;
    exp_retired = exp_retired + 32'd3;
    check("b2b_ir_count", n_ir, 3);
    check("b2b_step_count", n_step, 3);
    check("b2b_retired", retired, exp_retired);

    // Reset while waiting on the misc manager.
    @(negedge clk);
    run = 1'b1; dec_misc_cs = 1'b1; dec_reg_we = 1'b1; ip = 16'd9; bus.misc_ack = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    #1 check("rstio_pre_req", 32'(bus.misc_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstio_outs", 32'(obs()), 32'd0);
    check("rstio_retired", retired, 32'd0);
    @(negedge clk);
    run = 1'b0;
    #1 check("rstio_fetch", 32'(obs()), 32'b100000);
    do_reset();

    // Retired counter wrap from all-ones.
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    exp_retired = 32'hFFFF_FFFF;
    #1 check("wrap_preset", retired, exp_retired);
`ifndef CPU_SEQ_SINGLE_STEP_EN
    step_noise = 1'b1;
`endif
    run_instr("wrap", 16'd10, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    exp_s = '{6'b100000, 6'b000000, 6'b001100, 6'b000001, 6'b000000,
              6'b000000, 6'b100000, 6'b000000, 6'b001100};
    @(negedge clk);
    run = 1'b1; dec_misc_cs = 1'b0; dec_reg_we = 1'b1; ip = 16'd11;
    step_en = 1'b1; step_req = 1'b0; bus.misc_ack = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      step_req = (k == 5);
      step_en  = (k <= 5);
      run      = (k != 8);
      #1 check($sformatf("step_c%0d", k), 32'(obs()), 32'(exp_s[k]));
      if (k == 3) check("step_retired_wrap", retired, exp_retired + 32'd1);
    end
    @(negedge clk);
    run = 1'b0; step_req = 1'b0;
    #1;
    exp_retired = exp_retired + 32'd2;
    check("step_after", 32'(obs()), 32'd0);
    check("step_retired", retired, exp_retired);
`endif

    for (int i = 0; i < 40; i++) begin
      v.ip   = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 255));
      v.misc = 1'($urandom);
      v.we   = 1'($urandom);
      v.dly  = $urandom_range(0, 10);
      e = model_end(v.ip, v.misc, v.dly, r, t);
      run_instr($sformatf("rnd%0d", i), v.ip, v.misc, v.we, v.dly, e, r, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
